instruction_decode: RTL and testbench
=====================================

Name: instruction_decode

Overview:
- Second pipeline stage of the 5-stage MIPS core. Consumes the 64-bit IF/ID register {instruction, pc} produced by instruction fetch.
- Decodes the instruction, reads the register file, and resolves branches/jumps in ID.
- Detects load-use and branch-operand hazards and drives the fetch-stage controls (branchResult, branchAddrs, regStall, muxStall).
- Produces the 121-bit ID/EX pipeline register.

Parameters:
- RF_DEPTH, 32, number of architectural registers; address width is 5.
- NOP_ON_ILLEGAL, 1, when 1, an unknown opcode or funct emits an all-zero control bubble.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instructionFetchReg  in  64  IF/ID register: [63:32] instruction, [31:0] pc of that instruction
- wbEn  in  1  writeback enable
- wbAddr  in  5  writeback register
- wbData  in  32  writeback data
- exRegWrite  in  1  EX-stage instruction writes a register
- exMemRead  in  1  EX-stage instruction is a load
- exRd  in  5  EX-stage destination
- memMemRead  in  1  MEM-stage instruction is a load
- memRd  in  5  MEM-stage destination
- branchResult  out  1  redirect fetch; also flushes IF/ID
- branchAddrs  out  32  redirect target
- regStall  out  1  IF/ID load enable (1 = advance, 0 = hold)
- muxStall  out  1  PC hold (1 = hold)
- idExReg  out  121  ID/EX register

Behaviour:
- Reset (rst_n low, asynchronous):
  - idExReg = 0 and all registers = 0.
  - Combinational outputs are forced to branchResult = 0, branchAddrs = 0, regStall = 1, muxStall = 0.
- Supported instructions (opcode/funct in hex):
  - R-type 00 with funct add 20, sub 22, and 24, or 25, slt 2A
  - j 02, beq 04, bne 05, addi 08, lw 23, sw 2B
- idExReg layout:
  - [0] regWrite, [1] memRead, [2] memWrite, [3] memToReg, [4] aluSrc, [5] regDst, [9:6] aluOp (add 0, sub 1, and 2, or 3, slt 4)
  - [41:10] rsData, [73:42] rtData, [105:74] sign-extended imm
  - [110:106] rs, [115:111] rt, [120:116] rd
  - rd field = instr[15:11] for R-type, instr[20:16] otherwise.
  - regWrite is forced to 0 when the destination is r0, so the all-zero word is a true bubble.
- Register file:
  - Two combinational read ports; write on posedge when wbEn = 1 and wbAddr != 0.
  - r0 always reads 0.
  - Write-first bypass: a same-cycle read of wbAddr returns wbData.
- Hazards (combinational from the current IF/ID contents and the EX/MEM inputs):
  - Load-use stall when exMemRead = 1, exRd != 0, and exRd equals rs, or equals rt for an instruction that reads rt (R-type, beq, bne, sw).
  - Branch stall when the instruction is beq/bne and either:
    - exRegWrite = 1 and exRd != 0 matches rs or rt, or
    - memMemRead = 1 and memRd != 0 matches rs or rt.
  - Any stall: regStall = 0, muxStall = 1, branchResult = 0, and the next idExReg = 0 (bubble).
  - Latency of a stall is one cycle per cycle the condition holds.
- Branch resolution (no stall):
  - beq taken iff rsData == rtData; bne taken iff they differ.
  - Target = pc + 4 + (sext(imm) << 2), computed modulo 2^32.
  - j is always taken: target = {(pc+4)[31:28], instr[25:0], 2'b00}.
  - Taken: branchResult = 1, branchAddrs = target. Not taken: branchResult = 0, branchAddrs = 0.
  - The branch/jump itself enters ID/EX with all-zero control.
- idExReg updates on every posedge: the decoded value when not stalled, 0 when stalled.
- Illegal instruction: bubble control, but operand fields are still captured; no branch.
- Simultaneous WB write and stall: the write still occurs. Reset mid-stall clears everything immediately; the first cycle after release decodes whatever is in IF/ID.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct constants
  - aluOp codes
  - idExReg bit-index/field-offset localparams
  - instruction field slice positions
- One sub-module, register_file: 32x32, 2R1W, r0 = 0, write-first bypass, async active-low clear.

Test Plan:
- Reset: pulse rst_n low mid-run -> idExReg = 0, regStall = 1, muxStall = 0; lw-free decode of r5 gives rsData = 0.
- Bypass: wbEn = 1, wbAddr = 3, wbData = 0x1234 while IF/ID = add r4,r3,r3 -> next idExReg rsData = rtData = 0x1234, regWrite = 1, aluOp = 0, rd = 4.
- Load-use: exMemRead = 1, exRd = 8, IF/ID = add r9,r8,r1 -> regStall = 0, muxStall = 1, next idExReg = 0; drop exMemRead -> regStall = 1 and decode proceeds.
- Branch: r1 = r2 = 5, pc = 0x40, beq r1,r2,+3 -> branchResult = 1, branchAddrs = 0x50; the same operands with bne -> branchResult = 0.
- Jump: pc = 0x40, j 0x100 -> branchResult = 1, branchAddrs = 0x400. Negative offset: beq imm = 0xFFFF at pc 0x0 -> target 0x0.
- Branch hazard: beq r1,r2 with exRegWrite = 1, exRd = 1 -> branchResult = 0, stall for 1 cycle; then resolves with the correct target.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS decode stage:
//   - opcode / funct encodings of the supported instruction subset
//   - ALU operation codes and the packed ID/EX control word
//   - bit offsets of every field inside the 121-bit ID/EX register
//   - bit positions of the instruction fields
// -----------------------------------------------------------------------------
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  // Packed MSB-first, so reg_write lands on bit 0 and alu_op on [9:6].
  typedef struct packed {
    alu_op_e alu_op;
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    mem_write;
    logic    mem_read;
    logic    reg_write;
  } ctrl_t;

  // ID/EX register layout
  localparam int ID_EX_W     = 121;
  localparam int IDX_CTRL    = 0;
  localparam int CTRL_W      = 10;
  localparam int IDX_RS_DATA = 10;
  localparam int IDX_RT_DATA = 42;
  localparam int IDX_IMM     = 74;
  localparam int IDX_RS      = 106;
  localparam int IDX_RT      = 111;
  localparam int IDX_RD      = 116;

  // Instruction field positions
  localparam int INSTR_OPC   = 26;
  localparam int INSTR_RS    = 21;
  localparam int INSTR_RT    = 16;
  localparam int INSTR_RD    = 11;
  localparam int INSTR_FUNCT = 0;
  localparam int INSTR_IMM   = 0;
  localparam int INSTR_TGT   = 0;

endpackage

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 32 x 32-bit architectural register file, two combinational read ports and
// one synchronous write port. r0 is hard-wired to zero. A read of the address
// being written in the same cycle returns the write data (write-first bypass),
// so WB and ID can share a cycle without a hazard.
// Ports:
//   clk, rst_n        clock, asynchronous active-low clear of all registers
//   ra1_i / ra2_i     read addresses;  rd1_o / rd2_o  read data
//   we_i, wa_i, wd_i  write enable / address / data
// -----------------------------------------------------------------------------
module register_file #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] mem_q [DEPTH];
  logic        wr_en;

  assign wr_en = we_i && (wa_i != 5'd0);

  // NOTE: the array is cleared by reset because the pipeline must see all
  // registers as zero after reset; this rules out a RAM macro and costs flops.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    if (ra1_i == 5'd0)                rd1_o = '0;
    else if (wr_en && wa_i == ra1_i)  rd1_o = wd_i;
    else                              rd1_o = mem_q[ra1_i];
  end

  always_comb begin
    if (ra2_i == 5'd0)                rd2_o = '0;
    else if (wr_en && wa_i == ra2_i)  rd2_o = wd_i;
    else                              rd2_o = mem_q[ra2_i];
  end

endmodule

// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
// ID stage of the 5-stage MIPS pipeline: decodes the IF/ID word, reads the
// register file, resolves beq/bne/j, detects load-use and branch-operand
// hazards, and registers the 121-bit ID/EX word.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   instructionFetchReg      IF/ID: [63:32] instruction, [31:0] its pc
//   wbEn, wbAddr, wbData     register-file write from WB
//   exRegWrite, exMemRead, exRd   EX-stage destination info
//   memMemRead, memRd        MEM-stage load info
//   branchResult/branchAddrs fetch redirect and target
//   regStall                 IF/ID load enable (0 = hold)
//   muxStall                 PC hold (1 = hold)
//   idExReg                  registered ID/EX word
// -----------------------------------------------------------------------------
module instruction_decode
  import mips_pkg::*;
#(
  parameter int RF_DEPTH       = 32,
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [63:0]  instructionFetchReg,
  input  logic         wbEn,
  input  logic [4:0]   wbAddr,
  input  logic [31:0]  wbData,
  input  logic         exRegWrite,
  input  logic         exMemRead,
  input  logic [4:0]   exRd,
  input  logic         memMemRead,
  input  logic [4:0]   memRd,
  output logic         branchResult,
  output logic [31:0]  branchAddrs,
  output logic         regStall,
  output logic         muxStall,
  output logic [120:0] idExReg
);

  // Instruction fields
  logic [31:0] instr, pc;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd_r;
  logic [15:0] imm;
  logic [25:0] jtarget;

  assign instr   = instructionFetchReg[63:32];
  assign pc      = instructionFetchReg[31:0];
  assign opcode  = instr[INSTR_OPC +: 6];
  assign rs      = instr[INSTR_RS +: 5];
  assign rt      = instr[INSTR_RT +: 5];
  assign rd_r    = instr[INSTR_RD +: 5];
  assign funct   = instr[INSTR_FUNCT +: 6];
  assign imm     = instr[INSTR_IMM +: 16];
  assign jtarget = instr[INSTR_TGT +: 26];

  logic [31:0] imm_sext;
  assign imm_sext = {{16{imm[15]}}, imm};

  // Register file
  logic [31:0] rs_data, rt_data;

  register_file #(.DEPTH(RF_DEPTH)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (rs_data),
    .rd2_o (rt_data),
    .we_i  (wbEn),
    .wa_i  (wbAddr),
    .wd_i  (wbData)
  );

  // Decode
  ctrl_t ctrl;
  logic  is_rtype, is_beq, is_bne, is_j, reads_rt, illegal;
  logic [4:0] rd_field;

  assign rd_field = (opcode == OP_RTYPE) ? rd_r : rt;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    ctrl     = '0;
    is_rtype = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    reads_rt = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        is_rtype       = 1'b1;
        reads_rt       = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: begin
            illegal     = 1'b1;
            ctrl.alu_op = ALU_ADD;
          end
        endcase
      end
      OP_J:   is_j = 1'b1;
      OP_BEQ: begin
        is_beq   = 1'b1;
        reads_rt = 1'b1;
      end
      OP_BNE: begin
        is_bne   = 1'b1;
        reads_rt = 1'b1;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        reads_rt       = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // With bubbling disabled an unknown funct still executes as add; an
    // unknown opcode has no sensible meaning and always bubbles.
    if (illegal && (NOP_ON_ILLEGAL || !is_rtype)) ctrl = '0;
    // Writes to r0 are dropped here so an all-zero ID/EX word is a clean bubble.
    if (rd_field == 5'd0) ctrl.reg_write = 1'b0;
  end

  // Hazards
  logic load_use, br_hazard, stall;

  assign load_use = exMemRead && (exRd != 5'd0) &&
                    ((exRd == rs) || (reads_rt && (exRd == rt)));

  // beq/bne compare in ID, so any in-flight producer of an operand stalls.
  assign br_hazard = (is_beq || is_bne) && (
                       (exRegWrite && (exRd != 5'd0) && ((exRd == rs) || (exRd == rt))) ||
                       (memMemRead && (memRd != 5'd0) && ((memRd == rs) || (memRd == rt))));

  assign stall = load_use || br_hazard;

  // Branch resolution
  logic [31:0] pc_plus4, br_target, j_target, target;
  logic        taken, redirect;

  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], jtarget, 2'b00};
  assign taken     = is_j || (is_beq && (rs_data == rt_data)) ||
                     (is_bne && (rs_data != rt_data));
  assign target    = is_j ? j_target : br_target;

  // Fetch controls are held at their idle values while reset is asserted.
  assign redirect     = rst_n && !stall && taken;
  assign branchResult = redirect;
  assign branchAddrs  = redirect ? target : 32'd0;
  assign regStall     = !rst_n || !stall;
  assign muxStall     = rst_n && stall;

  // ID/EX register
  logic [ID_EX_W-1:0] decoded, id_ex_d, id_ex_q;

  always_comb begin
    decoded                         = '0;
    decoded[IDX_CTRL    +: CTRL_W]  = ctrl;
    decoded[IDX_RS_DATA +: 32]      = rs_data;
    decoded[IDX_RT_DATA +: 32]      = rt_data;
    decoded[IDX_IMM     +: 32]      = imm_sext;
    decoded[IDX_RS      +: 5]       = rs;
    decoded[IDX_RT      +: 5]       = rt;
    decoded[IDX_RD      +: 5]       = rd_field;
  end

  assign id_ex_d = stall ? '0 : decoded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) id_ex_q <= '0;
    else        id_ex_q <= id_ex_d;
  end

  assign idExReg = id_ex_q;

endmodule

// File: tb/tb_instruction_decode.sv
// -----------------------------------------------------------------------------
// tb_instruction_decode
// Directed vectors with hand-computed expectations. Each issued vector pushes
// its expected fetch controls and next ID/EX word into a queue; a monitor pops
// one entry per cycle, checks fetch controls at the falling edge and the
// registered ID/EX word just after the following rising edge.
// -----------------------------------------------------------------------------
module tb_instruction_decode;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  instructionFetchReg;
  logic         wbEn;
  logic [4:0]   wbAddr;
  logic [31:0]  wbData;
  logic         exRegWrite, exMemRead, memMemRead;
  logic [4:0]   exRd, memRd;
  logic         branchResult, regStall, muxStall;
  logic [31:0]  branchAddrs;
  logic [120:0] idExReg;

  always #5 clk = ~clk;

  instruction_decode dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instructionFetchReg (instructionFetchReg),
    .wbEn                (wbEn),
    .wbAddr              (wbAddr),
    .wbData              (wbData),
    .exRegWrite          (exRegWrite),
    .exMemRead           (exMemRead),
    .exRd                (exRd),
    .memMemRead          (memMemRead),
    .memRd               (memRd),
    .branchResult        (branchResult),
    .branchAddrs         (branchAddrs),
    .regStall            (regStall),
    .muxStall            (muxStall),
    .idExReg             (idExReg)
  );

  typedef struct {
    string        nm;
    logic         br;
    logic [31:0]  ba;
    logic         rs;
    logic         ms;
    logic [120:0] idex;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0, n_total = 0, n_issued = 0, n_done = 0;

  // Staged stimulus; wb/ex/mem fields return to 0 after each issue.
  logic        s_rst = 1'b0;
  logic [31:0] s_instr = '0, s_pc = '0;
  logic        s_wben = 1'b0, s_exrw = 1'b0, s_exmr = 1'b0, s_memmr = 1'b0;
  logic [4:0]  s_wba = '0, s_exrd = '0, s_memrd = '0;
  logic [31:0] s_wbd = '0;

  // Expected control words (hand-derived from the ID/EX layout)
  localparam logic [9:0] C_NONE = 10'h000;
  localparam logic [9:0] C_ADD  = 10'h021;
  localparam logic [9:0] C_SUB  = 10'h061;
  localparam logic [9:0] C_AND  = 10'h0A1;
  localparam logic [9:0] C_OR   = 10'h0E1;
  localparam logic [9:0] C_SLT  = 10'h121;
  localparam logic [9:0] C_ADDI = 10'h011;
  localparam logic [9:0] C_LW   = 10'h01B;
  localparam logic [9:0] C_SW   = 10'h014;
  localparam logic [9:0] C_ALUSRC_ONLY = 10'h010;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [120:0] mk(input logic [9:0] c, input logic [31:0] rsd, rtd, im,
                                      input logic [4:0] rs, rt, rd);
    return {rd, rt, rs, im, rtd, rsd, c};
  endfunction

  task automatic check(input string nm, input logic [120:0] act, input logic [120:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic go(input string nm, input logic br, input logic [31:0] ba,
                    input logic rs, input logic ms, input logic [120:0] idex);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n               = s_rst;
    instructionFetchReg = {s_instr, s_pc};
    wbEn       = s_wben;  wbAddr = s_wba;   wbData = s_wbd;
    exRegWrite = s_exrw;  exMemRead = s_exmr; exRd = s_exrd;
    memMemRead = s_memmr; memRd = s_memrd;
    e.nm = nm; e.br = br; e.ba = ba; e.rs = rs; e.ms = ms; e.idex = idex;
    q.push_back(e);
    n_issued++;
    s_wben = 1'b0; s_wba = '0; s_wbd = '0;
    s_exrw = 1'b0; s_exmr = 1'b0; s_exrd = '0;
    s_memmr = 1'b0; s_memrd = '0;
  endtask

  // Shorthands for the two common outcomes
  task automatic go_ok(input string nm, input logic [120:0] idex);
    go(nm, 1'b0, 32'd0, 1'b1, 1'b0, idex);
  endtask

  task automatic go_stall(input string nm);
    go(nm, 1'b0, 32'd0, 1'b0, 1'b1, '0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.nm, ".branchResult"}, branchResult, e.br);
        check({e.nm, ".branchAddrs"},  branchAddrs,  e.ba);
        check({e.nm, ".regStall"},     regStall,     e.rs);
        check({e.nm, ".muxStall"},     muxStall,     e.ms);
        @(posedge clk);
        #1;
        check({e.nm, ".idExReg"}, idExReg, e.idex);
        n_done++;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    instructionFetchReg = '0;
    wbEn = 1'b0; wbAddr = '0; wbData = '0;
    exRegWrite = 1'b0; exMemRead = 1'b0; exRd = '0;
    memMemRead = 1'b0; memRd = '0;
    repeat (2) @(posedge clk);

    // Reset held with a would-be-taken beq in IF/ID: outputs forced idle.
    s_rst = 1'b0; s_instr = itype(6'h04, 5'd0, 5'd0, 16'd3); s_pc = 32'h40;
    go_ok("reset", '0);

    // Release; write-first bypass of r3 into add r4,r3,r3
    s_rst = 1'b1; s_instr = rtype(5'd3, 5'd3, 5'd4, 6'h20); s_pc = 32'h0;
    s_wben = 1'b1; s_wba = 5'd3; s_wbd = 32'h1234;
    go_ok("bypass_add", mk(C_ADD, 32'h1234, 32'h1234, 32'h2020, 5'd3, 5'd3, 5'd4));

    // All-zero word (funct 0 is unsupported) while writing r1 = 5
    s_instr = 32'h0;
    s_wben = 1'b1; s_wba = 5'd1; s_wbd = 32'd5;
    go_ok("zero_word", '0);

    // sub r6,r1,r3 while writing r2 = 5
    s_instr = rtype(5'd1, 5'd3, 5'd6, 6'h22);
    s_wben = 1'b1; s_wba = 5'd2; s_wbd = 32'd5;
    go_ok("sub", mk(C_SUB, 32'd5, 32'h1234, 32'h3022, 5'd1, 5'd3, 5'd6));

    // Load-use on rs, then released
    s_instr = rtype(5'd8, 5'd1, 5'd9, 6'h20);
    s_exmr = 1'b1; s_exrd = 5'd8;
    go_stall("loaduse_rs");
    go_ok("loaduse_release", mk(C_ADD, 32'd0, 32'd5, 32'h4820, 5'd8, 5'd1, 5'd9));

    // beq r1,r2,+3 at 0x40 taken; bne same operands not taken
    s_instr = itype(6'h04, 5'd1, 5'd2, 16'd3); s_pc = 32'h40;
    go("beq_taken", 1'b1, 32'h50, 1'b1, 1'b0, mk(C_NONE, 32'd5, 32'd5, 32'd3, 5'd1, 5'd2, 5'd2));
    s_instr = itype(6'h05, 5'd1, 5'd2, 16'd3);
    go_ok("bne_not_taken", mk(C_NONE, 32'd5, 32'd5, 32'd3, 5'd1, 5'd2, 5'd2));

    // j 0x100 at 0x40
    s_instr = {6'h02, 26'h100};
    go("jump", 1'b1, 32'h400, 1'b1, 1'b0, mk(C_NONE, 32'd0, 32'd0, 32'h100, 5'd0, 5'd0, 5'd0));

    // beq r0,r0,-1 at 0: wraps back to 0
    s_instr = itype(6'h04, 5'd0, 5'd0, 16'hFFFF); s_pc = 32'h0;
    go("beq_neg", 1'b1, 32'h0, 1'b1, 1'b0, mk(C_NONE, 32'd0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0));

    // Branch hazard from EX on rs, then resolves
    s_instr = itype(6'h04, 5'd1, 5'd2, 16'd3); s_pc = 32'h40;
    s_exrw = 1'b1; s_exrd = 5'd1;
    go_stall("brhaz_ex");
    go("brhaz_release", 1'b1, 32'h50, 1'b1, 1'b0, mk(C_NONE, 32'd5, 32'd5, 32'd3, 5'd1, 5'd2, 5'd2));

    // Branch hazard from a MEM-stage load on rt
    s_instr = itype(6'h05, 5'd1, 5'd2, 16'd3);
    s_memmr = 1'b1; s_memrd = 5'd2;
    go_stall("brhaz_mem");

    // I-type decodes
    s_instr = itype(6'h08, 5'd1, 5'd7, 16'hFFFE); s_pc = 32'h0;
    go_ok("addi", mk(C_ADDI, 32'd5, 32'd0, 32'hFFFF_FFFE, 5'd1, 5'd7, 5'd7));
    s_instr = itype(6'h23, 5'd2, 5'd10, 16'd4);
    go_ok("lw", mk(C_LW, 32'd5, 32'd0, 32'd4, 5'd2, 5'd10, 5'd10));
    s_instr = itype(6'h2B, 5'd1, 5'd3, 16'd8);
    go_ok("sw", mk(C_SW, 32'd5, 32'h1234, 32'd8, 5'd1, 5'd3, 5'd3));

    // Remaining ALU ops
    s_instr = rtype(5'd1, 5'd2, 5'd11, 6'h24);
    go_ok("and", mk(C_AND, 32'd5, 32'd5, 32'h5824, 5'd1, 5'd2, 5'd11));
    s_instr = rtype(5'd1, 5'd2, 5'd11, 6'h25);
    go_ok("or", mk(C_OR, 32'd5, 32'd5, 32'h5825, 5'd1, 5'd2, 5'd11));
    s_instr = rtype(5'd1, 5'd2, 5'd11, 6'h2A);
    go_ok("slt", mk(C_SLT, 32'd5, 32'd5, 32'h582A, 5'd1, 5'd2, 5'd11));

    // Destination r0 drops regWrite; illegal opcode bubbles but keeps fields
    s_instr = itype(6'h08, 5'd1, 5'd0, 16'd5);
    go_ok("addi_r0", mk(C_ALUSRC_ONLY, 32'd5, 32'd0, 32'd5, 5'd1, 5'd0, 5'd0));
    s_instr = itype(6'h3F, 5'd1, 5'd2, 16'h0010);
    go_ok("illegal_op", mk(C_NONE, 32'd5, 32'd5, 32'h10, 5'd1, 5'd2, 5'd2));

    // Load-use boundaries: rt of addi is not a source; exRd = r0 never stalls
    s_instr = itype(6'h08, 5'd1, 5'd7, 16'd1);
    s_exmr = 1'b1; s_exrd = 5'd7;
    go_ok("loaduse_addi_rt", mk(C_ADDI, 32'd5, 32'd0, 32'd1, 5'd1, 5'd7, 5'd7));
    s_instr = rtype(5'd0, 5'd0, 5'd15, 6'h20);
    s_exmr = 1'b1; s_exrd = 5'd0;
    s_wben = 1'b1; s_wba = 5'd0; s_wbd = 32'hFFFF;
    go_ok("loaduse_r0_wr0", mk(C_ADD, 32'd0, 32'd0, 32'h7820, 5'd0, 5'd0, 5'd15));

    // Load-use through rt of sw
    s_instr = itype(6'h2B, 5'd1, 5'd3, 16'd8);
    s_exmr = 1'b1; s_exrd = 5'd3;
    go_stall("loaduse_sw_rt");

    // WB write lands during a stall
    s_instr = rtype(5'd9, 5'd0, 5'd13, 6'h20);
    s_exmr = 1'b1; s_exrd = 5'd9;
    s_wben = 1'b1; s_wba = 5'd12; s_wbd = 32'hAB;
    go_stall("wb_during_stall");
    s_instr = rtype(5'd12, 5'd0, 5'd13, 6'h20);
    go_ok("read_after_stall_wb", mk(C_ADD, 32'hAB, 32'd0, 32'h6820, 5'd12, 5'd0, 5'd13));

    // Reset mid-stall, then decode with a cleared register file
    s_rst = 1'b0; s_instr = rtype(5'd1, 5'd1, 5'd9, 6'h20);
    s_exmr = 1'b1; s_exrd = 5'd1;
    go_ok("reset_mid_stall", '0);
    s_rst = 1'b1; s_instr = rtype(5'd1, 5'd2, 5'd14, 6'h20);
    go_ok("after_reset", mk(C_ADD, 32'd0, 32'd0, 32'h7020, 5'd1, 5'd2, 5'd14));

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && n_done < n_issued; i++) @(posedge clk);
    #3;
    if (n_done < n_issued) begin
      n_total++;
      $display("FAIL drain: %0d of %0d vectors checked", n_done, n_issued);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
